// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the RV32 pipeline flow controller.
//   - state_t        : controller FSM states
//   - REG_W          : register-file index width
//   - CNT_W_DEF      : default width of the stall-cycle counter
//   - MD_MAX_CYC_DEF : default MDU watchdog limit in cycles
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W          = 5;
    localparam int CNT_W_DEF      = 16;
    localparam int MD_MAX_CYC_DEF = 40;

    typedef enum logic [1:0] {
        RUN       = 2'd0,   // normal flow, hazards resolved combinationally
        MD_WAIT   = 2'd1,   // multi-cycle MUL/DIV in EX, back end frozen
        IMEM_WAIT = 2'd2    // instruction fetch outstanding
    } state_t;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use hazard detector.
//   Ports:
//     Rs1D, Rs2D  in  REG_W  source registers of the instruction in ID
//     RdE         in  REG_W  destination register of the instruction in EX
//     MemReadE    in  1      instruction in EX is a load
//     RegWriteE   in  1      instruction in EX writes the register file
//     lu          out 1      ID consumes the result of the load now in EX
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdE,
    input  logic             MemReadE,
    input  logic             RegWriteE,
    output logic             lu
);

    logic [REG_W-1:0] src [2];
    logic [1:0]       src_match;

    assign src[0] = Rs1D;
    assign src[1] = Rs2D;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = (src[gi] == RdE);
        end
    endgenerate

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign lu = MemReadE & RegWriteE & (RdE != '0) & (|src_match);

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline flow controller for the 5-stage RV32 core. Produces stall and
//   flush enables for the PC, IF/ID, ID/EX and EX/MEM registers, sequencing
//   load-use hazards, EX-resolved redirects, multi-cycle MDU operations and
//   instruction-memory wait states. Also keeps a saturating stall-cycle
//   counter and a sticky MDU watchdog error flag.
//
//   Parameters:
//     CNT_W       width of StallCnt
//     MD_MAX_CYC  MD_WAIT cycles allowed before the watchdog fires
//   Ports:
//     clk          in   1      system clock, rising edge
//     rst          in   1      asynchronous active-low reset
//     Rs1D, Rs2D   in   REG_W  ID source registers
//     RdE          in   REG_W  EX destination register
//     MemReadE     in   1      EX instruction is a load
//     RegWriteE    in   1      EX instruction writes the register file
//     PCSrcE       in   1      taken branch/jump resolved in EX
//     MdStartE     in   1      MUL/DIV enters EX this cycle
//     MdDoneE      in   1      MDU result valid this cycle
//     ImemReadyF   in   1      instruction memory returns InstrF this cycle
//     StallF/D/E   out  1      hold PC, IF/ID, ID/EX
//     FlushD/E/M   out  1      bubble into IF/ID, ID/EX, EX/MEM
//     StallCnt     out  CNT_W  saturating count of StallF cycles
//     MdTimeout    out  1      sticky MDU watchdog error
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MD_MAX_CYC = MD_MAX_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdE,
    input  logic             MemReadE,
    input  logic             RegWriteE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    input  logic             ImemReadyF,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [CNT_W-1:0] StallCnt,
    output logic             MdTimeout
);

    localparam int MD_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_MAX_CYC - 1);

    state_t           state_reg, state_next;
    logic             redir_pend_reg, redir_pend_next;
    logic [MD_W-1:0]  md_cnt_reg, md_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             md_timeout_reg;
    logic             timeout_set;

    logic lu;
    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, flush_m;

    hazard_detect u_hazard_detect (
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdE       (RdE),
        .MemReadE  (MemReadE),
        .RegWriteE (RegWriteE),
        .lu        (lu)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= RUN;
            redir_pend_reg <= 1'b0;
            md_cnt_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            redir_pend_reg <= redir_pend_next;
            md_cnt_reg     <= md_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        redir_pend_next = redir_pend_reg;
        md_cnt_next     = md_cnt_reg;
        timeout_set     = 1'b0;
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        stall_e         = 1'b0;
        flush_d         = 1'b0;
        flush_e         = 1'b0;
        flush_m         = 1'b0;

        unique case (state_reg)
            RUN: begin
                if (PCSrcE) begin
                    // Redirect squashes ID and EX; any hazard behind it is moot.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (MdStartE) begin
                    stall_f     = 1'b1;
                    stall_d     = 1'b1;
                    stall_e     = 1'b1;
                    flush_m     = 1'b1;
                    md_cnt_next = '0;
                    state_next  = MD_WAIT;
                end else begin
                    if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                    if (!ImemReadyF) begin
                        stall_f    = 1'b1;
                        // IF/ID must hold the stalled ID instruction while a
                        // load-use bubble is inserted, so only bubble it
                        // when ID is free to move.
                        if (!lu) begin
                            flush_d = 1'b1;
                        end
                        state_next = IMEM_WAIT;
                    end
                end
            end

            MD_WAIT: begin
                // Redirects cannot arrive here: EX is frozen on the MDU op.
                if (MdDoneE) begin
                    state_next = RUN;
                end else begin
                    stall_f     = 1'b1;
                    stall_d     = 1'b1;
                    stall_e     = 1'b1;
                    flush_m     = 1'b1;
                    md_cnt_next = md_cnt_reg + MD_W'(1);
                    if (md_cnt_reg == MD_LAST) begin
                        timeout_set = 1'b1;
                        state_next  = RUN;
                    end
                end
            end

            IMEM_WAIT: begin
                if (PCSrcE) begin
                    flush_e = 1'b1;
                end
                if (!ImemReadyF) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    if (PCSrcE) begin
                        redir_pend_next = 1'b1;
                    end
                end else begin
                    // A word fetched before a redirect is on the wrong path.
                    flush_d         = redir_pend_reg | PCSrcE;
                    redir_pend_next = 1'b0;
                    state_next      = RUN;
                end
            end

            default: begin
                state_next      = RUN;
                redir_pend_next = 1'b0;
            end
        endcase
    end

    // Outputs are gated by reset so they drop without waiting for a clock.
    assign StallF = rst & stall_f;
    assign StallD = rst & stall_d;
    assign StallE = rst & stall_e;
    assign FlushD = rst & flush_d;
    assign FlushE = rst & flush_e;
    assign FlushM = rst & flush_m;

    // -----------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_f && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sticky MDU watchdog flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_timeout_reg <= 1'b0;
        end else if (timeout_set) begin
            md_timeout_reg <= 1'b1;
        end
    end

    assign StallCnt  = stall_cnt_reg;
    assign MdTimeout = md_timeout_reg;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed self-checking bench for pipe_ctrl. Inputs change 1 ns after the
//   rising edge; combinational outputs are sampled 2 ns later, registered
//   values 1 ns after the edge that updates them. Output vectors are packed
//   as {StallF, StallD, StallE, FlushD, FlushE, FlushM}.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] Rs1D, Rs2D, RdE;
    logic             MemReadE, RegWriteE, PCSrcE, MdStartE, MdDoneE, ImemReadyF;

    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdTimeout;
    logic [15:0] StallCnt;

    logic        s4_stall_f, s4_stall_d, s4_stall_e;
    logic        s4_flush_d, s4_flush_e, s4_flush_m, s4_md_timeout;
    logic [3:0]  s4_stall_cnt;

    logic [5:0]  outs;
    assign outs = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdE        (RdE),
        .MemReadE   (MemReadE),
        .RegWriteE  (RegWriteE),
        .PCSrcE     (PCSrcE),
        .MdStartE   (MdStartE),
        .MdDoneE    (MdDoneE),
        .ImemReadyF (ImemReadyF),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .StallCnt   (StallCnt),
        .MdTimeout  (MdTimeout)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdE        (RdE),
        .MemReadE   (MemReadE),
        .RegWriteE  (RegWriteE),
        .PCSrcE     (PCSrcE),
        .MdStartE   (MdStartE),
        .MdDoneE    (MdDoneE),
        .ImemReadyF (ImemReadyF),
        .StallF     (s4_stall_f),
        .StallD     (s4_stall_d),
        .StallE     (s4_stall_e),
        .FlushD     (s4_flush_d),
        .FlushE     (s4_flush_e),
        .FlushM     (s4_flush_m),
        .StallCnt   (s4_stall_cnt),
        .MdTimeout  (s4_md_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdE = '0;
        MemReadE = 1'b0; RegWriteE = 1'b0;
        PCSrcE = 1'b0; MdStartE = 1'b0; MdDoneE = 1'b0;
        ImemReadyF = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        Rs1D = rs1; Rs2D = rs2; RdE = rd;
        MemReadE = 1'b1; RegWriteE = 1'b1;
    endtask

    // Check combinational outputs for the current inputs, then advance a cycle.
    task automatic cyc(input string tag, input logic [5:0] exp);
        #2;
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        // ---- reset state, with stall-provoking inputs present ----
        idle();
        ImemReadyF = 1'b0;
        MdStartE   = 1'b1;
        #2;
        check("rst_outs", 32'(outs), 32'(6'b000000));
        check("rst_cnt", 32'(StallCnt), 32'd0);
        check("rst_tmo", 32'(MdTimeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // ---- load-use ----
        set_load(5'd5, 5'd0, 5'd5);
        cyc("lu_rs1", 6'b110010);
        idle();
        cyc("lu_after", 6'b000000);
        check("lu_cnt", 32'(StallCnt), 32'd1);
        set_load(5'd3, 5'd7, 5'd7);
        cyc("lu_rs2", 6'b110010);
        set_load(5'd0, 5'd0, 5'd0);
        cyc("lu_x0", 6'b000000);
        set_load(5'd5, 5'd0, 5'd5);
        RegWriteE = 1'b0;
        cyc("lu_nowr", 6'b000000);
        idle();

        // ---- taken branch ----
        PCSrcE = 1'b1;
        cyc("br", 6'b000110);
        set_load(5'd5, 5'd0, 5'd5);
        cyc("br_lu", 6'b000110);
        idle();
        PCSrcE = 1'b1; MdStartE = 1'b1;
        cyc("br_md", 6'b000110);
        idle();
        cyc("br_after", 6'b000000);
        check("br_cnt", 32'(StallCnt), 32'd2);

        // ---- MDU completing after 33 cycles ----
        do_reset();
        MdStartE = 1'b1;
        cyc("md_start", 6'b111001);
        idle();
        for (int i = 1; i < 33; i++) begin
            PCSrcE = (i == 10);
            cyc($sformatf("md_wait%0d", i), 6'b111001);
        end
        idle();
        MdDoneE = 1'b1;
        cyc("md_done", 6'b000000);
        idle();
        check("md_cnt33", 32'(StallCnt), 32'd33);
        cyc("md_run", 6'b000000);
        check("md_tmo0", 32'(MdTimeout), 32'd0);

        // ---- MDU watchdog ----
        do_reset();
        MdStartE = 1'b1;
        cyc("wd_start", 6'b111001);
        idle();
        for (int i = 1; i <= 40; i++) begin
            if (i == 40) check("wd_pre", 32'(MdTimeout), 32'd0);
            cyc($sformatf("wd_wait%0d", i), 6'b111001);
        end
        check("wd_tmo", 32'(MdTimeout), 32'd1);
        check("wd_cnt", 32'(StallCnt), 32'd41);
        ImemReadyF = 1'b0;
        cyc("wd_run", 6'b100100);
        idle();
        cyc("wd_idle", 6'b000000);
        check("wd_sticky", 32'(MdTimeout), 32'd1);

        // ---- imem wait with redirect ----
        do_reset();
        ImemReadyF = 1'b0;
        cyc("im_w1", 6'b100100);
        PCSrcE = 1'b1;
        cyc("im_w2_br", 6'b100110);
        PCSrcE = 1'b0;
        cyc("im_w3", 6'b100100);
        ImemReadyF = 1'b1;
        cyc("im_rdy_redir", 6'b000100);
        cyc("im_run", 6'b000000);
        check("im_cnt", 32'(StallCnt), 32'd3);

        // ---- imem wait without redirect ----
        ImemReadyF = 1'b0;
        cyc("im2_w1", 6'b100100);
        ImemReadyF = 1'b1;
        cyc("im2_rdy", 6'b000000);
        cyc("im2_run", 6'b000000);

        // ---- load-use together with imem miss still enters IMEM_WAIT ----
        set_load(5'd9, 5'd0, 5'd9);
        ImemReadyF = 1'b0;
        cyc("luim", 6'b110010);
        idle();
        ImemReadyF = 1'b0; PCSrcE = 1'b1;
        cyc("luim_wait_br", 6'b100110);
        idle();
        cyc("luim_rdy", 6'b000100);
        cyc("luim_run", 6'b000000);

        // ---- reset in the 5th MD_WAIT cycle ----
        do_reset();
        MdStartE = 1'b1;
        cyc("rm_start", 6'b111001);
        idle();
        for (int i = 1; i <= 4; i++) cyc($sformatf("rm_wait%0d", i), 6'b111001);
        #2;
        check("rm_wait5", 32'(outs), 32'(6'b111001));
        rst = 1'b0;
        #1;
        check("rm_outs", 32'(outs), 32'(6'b000000));
        check("rm_cnt", 32'(StallCnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ImemReadyF = 1'b0;
        cyc("rm_run", 6'b100100);
        idle();
        cyc("rm_idle", 6'b000000);

        // ---- counter saturation ----
        do_reset();
        ImemReadyF = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc($sformatf("sat%0d", i), 6'b100100);
            if (i == 15) check("sat4_at15", 32'(s4_stall_cnt), 32'd15);
        end
        check("sat4_at20", 32'(s4_stall_cnt), 32'd15);
        check("sat16_at20", 32'(StallCnt), 32'd20);
        idle();
        cyc("sat_rdy", 6'b000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipe_ctrl
